// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: strobe/ack register bank with ID, W1C status, IRQ enable, cycle counter and byte-writable CTRL regs.
// Defining CFG_REG_BANK_CYCLE_CNT_EN builds the free-running cycle counter at 0x0C; otherwise 0x0C is unmapped.
module cfg_reg_bank #(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0100,
    parameter int unsigned NUM_CTRL    = 4,
    parameter int unsigned NUM_EVT     = 8,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VER      = 32'h0123_4567,
    parameter logic [31:0] CTRL_RST    = 32'h0000_0000
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [31:0]              iADR,
    input  logic [31:0]              iDAT,
    input  logic [3:0]               iSEL,
    input  logic                     iSTB,
    input  logic                     iWE,
    output logic [31:0]              oDAT,
    output logic                     oACK,
    input  logic [NUM_EVT-1:0]       iEVT,
    output logic                     oIRQ,
    output logic [32*NUM_CTRL-1:0]   oCTRL
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t             state, state_next;
    logic [3:0]         count, count_next;
    logic [5:0]         word_q;
    logic [31:0]        dat_q;
    logic [3:0]         sel_q;
    logic               we_q;

    logic               hit, commit;
    logic [5:0]         t_word;
    logic [31:0]        t_dat, t_mask, t_wbits;
    logic [3:0]         t_sel;
    logic               t_we;
    logic [31:0]        rd_val;
    logic [NUM_EVT-1:0] status, irq_en, status_clr;
    logic [31:0]        ctrl [NUM_CTRL];
    logic               unused_adr;
`ifdef CFG_REG_BANK_CYCLE_CNT_EN
    logic [31:0]        cycle;
`endif

    assign hit        = (iADR[31:8] == BASE_ADDR[31:8]);
    assign unused_adr = ^iADR[1:0];

    // With zero wait states the commit edge is the acceptance edge, so the live bus is used directly.
    assign t_word  = (state == IDLE) ? iADR[7:2] : word_q;
    assign t_dat   = (state == IDLE) ? iDAT      : dat_q;
    assign t_sel   = (state == IDLE) ? iSEL      : sel_q;
    assign t_we    = (state == IDLE) ? iWE       : we_q;
    assign t_mask  = {{8{t_sel[3]}}, {8{t_sel[2]}}, {8{t_sel[1]}}, {8{t_sel[0]}}};
    assign t_wbits = t_dat & t_mask;
    assign commit  = (state_next == ACK);
    assign oACK    = (state == ACK);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (iSTB && hit) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!iSTB) begin
                    state_next = IDLE;
                end else if (count == 4'd1) begin
                    state_next = ACK;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            ACK:     state_next = HOLD;
            HOLD:    if (!iSTB) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            count  <= '0;
            word_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == IDLE && iSTB && hit) begin
                word_q <= iADR[7:2];
                dat_q  <= iDAT;
                sel_q  <= iSEL;
                we_q   <= iWE;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (t_word)
            6'd0: rd_val = ID_VER;
            6'd1: rd_val[NUM_EVT-1:0] = status;
            6'd2: rd_val[NUM_EVT-1:0] = irq_en;
`ifdef CFG_REG_BANK_CYCLE_CNT_EN
            6'd3: rd_val = cycle;
`endif
            default: ;
        endcase
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (t_word == 6'(k + 4)) rd_val = ctrl[k];
        end
    end

    always_comb begin
        status_clr = '0;
        if (commit && t_we && t_word == 6'd1) status_clr = t_wbits[NUM_EVT-1:0];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            status <= '0;
            irq_en <= '0;
            oIRQ   <= 1'b0;
            oDAT   <= '0;
            for (int unsigned k = 0; k < NUM_CTRL; k++) ctrl[k] <= CTRL_RST;
        end else begin
            // A new event on the clearing edge survives the W1C.
            status <= (status & ~status_clr) | iEVT;
            oIRQ   <= |(status & irq_en);
            oDAT   <= (commit && !t_we) ? rd_val : '0;
            if (commit && t_we && t_word == 6'd2)
                irq_en <= (irq_en & ~t_mask[NUM_EVT-1:0]) | t_wbits[NUM_EVT-1:0];
            for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                if (commit && t_we && t_word == 6'(k + 4))
                    ctrl[k] <= (ctrl[k] & ~t_mask) | t_wbits;
            end
        end
    end

`ifdef CFG_REG_BANK_CYCLE_CNT_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) cycle <= '0;
        else      cycle <= cycle + 32'd1;
    end
`endif

    always_comb begin
        oCTRL = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) oCTRL[32*k +: 32] = ctrl[k];
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Scoreboard bench for cfg_reg_bank: two instances (0 and 3 wait states) against a behavioural register model.
// Honours CFG_REG_BANK_CYCLE_CNT_EN when checking offset 0x0C.
module tb_cfg_reg_bank;

    localparam logic [31:0] BASE = 32'h0200_0100;
    localparam logic [31:0] ID0  = 32'h0123_4567;
    localparam logic [31:0] ID1  = 32'hCAFE_0001;
    localparam logic [31:0] RST1 = 32'h5A5A_0000;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  adr = '0;
    logic [31:0]  dat = '0;
    logic [3:0]   sel = '0;
    logic         we  = 1'b0;
    logic [1:0]   stb = '0;
    logic [7:0]   evt = '0;
    logic [31:0]  rdat [2];
    logic         ack [2];
    logic         irq [2];
    logic [127:0] ctrl_o [2];

    int           tests = 0;
    int           fails = 0;
    exp_t         q0[$];
    exp_t         q1[$];

    int           wait_of [2]  = '{0, 3};
    logic [31:0]  id_of [2]    = '{ID0, ID1};
    logic [31:0]  rst_of [2]   = '{32'h0, RST1};
    logic [31:0]  evmask [2]   = '{32'h0000_00FF, 32'h0000_001F};
    logic [31:0]  m_status [2];
    logic [31:0]  m_irq_en [2];
    logic [31:0]  m_ctrl [2][4];

`ifdef CFG_REG_BANK_CYCLE_CNT_EN
    int unsigned  edge_cnt = 0;
    int unsigned  last_ack_edge = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end
`endif

    always #5 clk = ~clk;

    cfg_reg_bank dut0 (
        .iCLK(clk), .iRST(rst), .iADR(adr), .iDAT(dat), .iSEL(sel), .iSTB(stb[0]), .iWE(we),
        .oDAT(rdat[0]), .oACK(ack[0]), .iEVT(evt), .oIRQ(irq[0]), .oCTRL(ctrl_o[0])
    );

    cfg_reg_bank #(
        .WAIT_CYCLES(3),
        .NUM_EVT(5),
        .ID_VER(ID1),
        .CTRL_RST(RST1)
    ) dut1 (
        .iCLK(clk), .iRST(rst), .iADR(adr), .iDAT(dat), .iSEL(sel), .iSTB(stb[1]), .iWE(we),
        .oDAT(rdat[1]), .oACK(ack[1]), .iEVT(evt[4:0]), .oIRQ(irq[1]), .oCTRL(ctrl_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int w;
        w = int'(a[7:2]);
        if (w == 0) return id_of[d];
        if (w == 1) return m_status[d];
        if (w == 2) return m_irq_en[d];
        if (w >= 4 && w < 8) return m_ctrl[d][w-4];
        return '0;
    endfunction

    function automatic logic model_chk(input logic [31:0] a);
`ifdef CFG_REG_BANK_CYCLE_CNT_EN
        return a[7:2] != 6'd3;
`else
        return a[1] | ~a[1];
`endif
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] m;
        int w;
        m = byte_mask(s);
        w = int'(a[7:2]);
        if (w == 1) m_status[d] = m_status[d] & ~(wd & m);
        else if (w == 2) m_irq_en[d] = ((m_irq_en[d] & ~m) | (wd & m)) & evmask[d];
        else if (w >= 4 && w < 8) m_ctrl[d][w-4] = (m_ctrl[d][w-4] & ~m) | (wd & m);
    endtask

    task automatic model_evt(input logic [7:0] ev);
        for (int d = 0; d < 2; d++) m_status[d] = m_status[d] | ({24'h0, ev} & evmask[d]);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_status[d] = '0;
            m_irq_en[d] = '0;
            for (int k = 0; k < 4; k++) m_ctrl[d][k] = rst_of[d];
        end
    endtask

    task automatic check_ctrl(input int d);
        for (int k = 0; k < 4; k++)
            check($sformatf("ctrl%0d_dut%0d", k, d), ctrl_o[d][32*k +: 32], m_ctrl[d][k]);
    endtask

    task automatic check_irq();
        for (int d = 0; d < 2; d++)
            check($sformatf("irq_dut%0d", d), 32'(irq[d]), 32'(|(m_status[d] & m_irq_en[d])));
    endtask

    // One bus transaction; ev is driven alongside the strobe for one edge.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                       input logic w, input logic [7:0] ev, input int hold_extra, output logic [31:0] got_data);
        exp_t e;
        logic in_win;
        logic got;
        int   cyc;
        in_win = (a[31:8] == BASE[31:8]);
        if (in_win) begin
            e.chk  = !w && model_chk(a);
            e.data = w ? '0 : model_read(d, a);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        adr = a; dat = wd; sel = s; we = w; evt = ev; stb[d] = 1'b1;
        cyc = 0; got = 1'b0; got_data = '0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            evt = '0;
            if (ack[d]) begin
                got = 1'b1;
                got_data = rdat[d];
`ifdef CFG_REG_BANK_CYCLE_CNT_EN
                last_ack_edge = edge_cnt;
`endif
            end else if (in_win && cyc == 1) begin
                adr = $urandom; dat = $urandom; sel = 4'($urandom); we = ~w;
            end
        end
        if (in_win) begin
            check($sformatf("ack_latency_dut%0d", d), 32'(got ? cyc : 0), 32'(wait_of[d] + 1));
        end else begin
            check($sformatf("miss_no_ack_dut%0d", d), 32'(got), 32'h0);
            check($sformatf("miss_data_dut%0d", d), rdat[d], 32'h0);
        end
        repeat (hold_extra) @(negedge clk);
        stb[d] = 1'b0;
        @(negedge clk);
        if (got && w) model_write(d, a, wd, s);
        if (ev != 8'h0) model_evt(ev);
    endtask

    task automatic pulse_evt(input logic [7:0] ev);
        @(negedge clk); evt = ev;
        @(negedge clk); evt = '0;
        @(negedge clk);
        model_evt(ev);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ack[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack_dut%0d: got ack 1, required ack 0", d);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (e.chk) check($sformatf("read_data_dut%0d", d), rdat[d], e.data);
                end
            end else begin
                check($sformatf("idle_data_zero_dut%0d", d), rdat[d], 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        int words [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 63};
        int d, r, acks;
        logic [31:0] a;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ack_dut%0d", i), 32'(ack[i]), 32'h0);
            check($sformatf("rst_irq_dut%0d", i), 32'(irq[i]), 32'h0);
            check_ctrl(i);
        end
        rst = 1'b0;
        @(negedge clk);

        // ID reads, empty CTRL, held strobe
        txn(0, BASE, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(0, BASE + 32'h10, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(1, BASE, '0, 4'hF, 1'b0, 8'h0, 10, rd);

        // byte-masked CTRL write and readback
        for (int i = 0; i < 2; i++) begin
            txn(i, BASE + 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b1, 8'h0, 0, rd);
            check_ctrl(i);
            txn(i, BASE + 32'h14, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        end
        check("ctrl1_masked_dut0", ctrl_o[0][63:32], 32'h00BB_00DD);

        // strobe dropped during wait states: no ack, no write
        @(negedge clk);
        adr = BASE + 32'h18; dat = 32'hDEAD_BEEF; sel = 4'hF; we = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        stb[1] = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'h0);
        check_ctrl(1);

        // event, IRQ timing, W1C racing a new event
        txn(0, BASE + 32'h08, 32'h0000_0004, 4'hF, 1'b1, 8'h0, 0, rd);
        @(negedge clk); evt = 8'h04;
        @(negedge clk); evt = 8'h00;
        check("irq_not_early", 32'(irq[0]), 32'h0);
        @(negedge clk);
        check("irq_next_cycle", 32'(irq[0]), 32'h1);
        model_evt(8'h04);
        txn(0, BASE + 32'h04, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(0, BASE + 32'h04, 32'h0000_0004, 4'hF, 1'b1, 8'h04, 0, rd);
        txn(0, BASE + 32'h04, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        check_irq();
        txn(0, BASE + 32'h04, 32'h0000_0004, 4'hF, 1'b1, 8'h0, 0, rd);
        check("irq_cleared", 32'(irq[0]), 32'h0);
        check_irq();

        // window misses and unmapped in-window offsets
        txn(0, 32'h0200_0000, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(1, 32'h0200_0200, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(0, BASE + 32'hF0, '0, 4'hF, 1'b0, 8'h0, 0, rd);
        txn(1, BASE + 32'hF0, 32'hFFFF_FFFF, 4'hF, 1'b1, 8'h0, 0, rd);
        check_ctrl(1);

`ifdef CFG_REG_BANK_CYCLE_CNT_EN
        begin
            int unsigned e1;
            txn(0, BASE + 32'h0C, '0, 4'hF, 1'b0, 8'h0, 0, c1);
            e1 = last_ack_edge;
            repeat (2) @(negedge clk);
            txn(0, BASE + 32'h0C, '0, 4'hF, 1'b0, 8'h0, 0, c2);
            check("cycle_delta", c2 - c1, 32'(last_ack_edge - e1));
        end
`else
        txn(0, BASE + 32'h0C, '0, 4'hF, 1'b0, 8'h0, 0, c1);
        txn(1, BASE + 32'h0C, 32'h1234_5678, 4'hF, 1'b1, 8'h0, 0, rd);
        txn(1, BASE + 32'h0C, '0, 4'hF, 1'b0, 8'h0, 0, c2);
        check("cycle_absent", c1 | c2, 32'h0);
`endif

        // reset in the middle of a waited write
        @(negedge clk);
        adr = BASE + 32'h10; dat = 32'h1234_5678; sel = 4'hF; we = 1'b1; stb[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_wait_ack", 32'(ack[1]), 32'h0);
        stb[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_ctrl(0);
        check_ctrl(1);
        txn(1, BASE + 32'h10, '0, 4'hF, 1'b0, 8'h0, 0, rd);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pulse_evt(8'($urandom));
            end else begin
                a = BASE | (32'(words[$urandom_range(0, 9)]) << 2) | 32'($urandom_range(0, 3));
                txn(d, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), 8'h0, 0, rd);
            end
            check_ctrl(0);
            check_ctrl(1);
            check_irq();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(q0.size() + q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
Name: cfg_reg_bank

Overview:
Parametrised memory-mapped register bank on the single-master strobe/ack peripheral bus. It provides:
- read-only ID word
- sticky event status (write-1-to-clear) with interrupt enable and interrupt output
- free-running cycle counter
- NUM_CTRL byte-writable control registers driven out to the datapath

Transactions are registered with a programmable number of wait states before a single-cycle acknowledge. It replaces fixed constant-register slaves in the peripheral address space.

Parameters:
BASE_ADDR, 32'h0200_0100, window base; must be aligned to 256 bytes.
NUM_CTRL, 4, number of RW control registers (1..8).
NUM_EVT, 8, number of event/status bits (1..32).
WAIT_CYCLES, 0, wait states between acceptance and ACK (0..15).
ID_VER, 32'h0123_4567, value returned at offset 0x00.
CTRL_RST, 32'h0000_0000, reset value of every CTRL register.

Ports:
iCLK  in  1  clock.
iRST  in  1  reset; asynchronous, active-high.
iADR  in  32  byte address.
iDAT  in  32  write data.
iSEL  in  4  byte enables for writes; bit n enables byte n.
iSTB  in  1  strobe, active high; master holds it until oACK.
iWE  in  1  1 = write, 0 = read.
oDAT  out  32  read data; valid only while oACK=1, otherwise 0.
oACK  out  1  single-cycle acknowledge.
iEVT  in  NUM_EVT  event pulses; level sampled each clock.
oIRQ  out  1  registered interrupt.
oCTRL  out  32*NUM_CTRL  control registers concatenated; CTRL[k] at bits 32k+31:32k.

Behaviour:
- Reset (async on iRST high): state=IDLE, oACK=0, oDAT=0, oIRQ=0, STATUS=0, IRQ_EN=0, CYCLE=0, every CTRL=CTRL_RST.
- Window hit: iADR[31:8]==BASE_ADDR[31:8]. iADR[1:0] are ignored.
- Misses:
  - Outside the window: never acknowledged; the slave stays IDLE.
  - Inside the window but unmapped: acknowledged, read 0, writes ignored.
- Register map (offset):
  - 0x00 ID: RO, ID_VER.
  - 0x04 STATUS: W1C, bits NUM_EVT-1:0, upper bits read 0.
  - 0x08 IRQ_EN: RW, same width as STATUS.
  - 0x0C CYCLE: RO.
  - 0x10+4k CTRL[k]: RW, k < NUM_CTRL.
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE: on an edge with iSTB=1 and window hit, latch iADR, iDAT, iSEL, iWE. Go to WAIT with count=WAIT_CYCLES, or directly to ACK if WAIT_CYCLES=0.
  - WAIT: count decrements each cycle; go to ACK on the edge where count reaches 1. If iSTB=0 is sampled: abort, return to IDLE, no commit, no ACK.
  - ACK: oACK=1 for exactly one cycle, then HOLD.
  - HOLD: wait for iSTB=0, then IDLE. This prevents a held strobe from repeating the access.
- Latency: oACK is high in the cycle 1+WAIT_CYCLES clocks after iSTB is first sampled high.
- Commit point is the edge entering ACK:
  - Read data is registered into oDAT at that edge.
  - Writes update the target register at that edge.
  - Readback in the next transaction sees the new value.
- Write rules:
  - CTRL and IRQ_EN are byte-masked by iSEL.
  - STATUS clears bit i where iDAT[i]=1 and its byte is enabled.
  - Writes to ID and CYCLE are ignored but still acknowledged.
- STATUS set: bit i is set on any edge with iEVT[i]=1. Simultaneous set and W1C clear: set wins.
- CYCLE: increments every clock and wraps at 32'hFFFF_FFFF to 0. A read returns the value at the commit edge.
- oIRQ: registered |(STATUS & IRQ_EN), one cycle after the source change.
- Master changing the address or data during WAIT: the latched values are used.
- Reset during WAIT or ACK: the transaction is dropped and any uncommitted write is lost.

Optional Feature:
CFG_REG_BANK_CYCLE_CNT_EN
- Defined: CYCLE counter is present as described.
- Undefined: no counter logic is instantiated; offset 0x0C behaves as unmapped (acknowledged, reads 0).

Test Plan:
1. Reset, WAIT_CYCLES=0: read 0x0200_0100 -> oACK one cycle after the strobe edge, oDAT=32'h0123_4567; read 0x0200_0110 -> 0.
2. Write 0x0200_0114, iDAT=32'hAABB_CCDD, iSEL=4'b0101 -> oCTRL[63:32]=32'h00BB_00DD; readback matches.
3. WAIT_CYCLES=3: read ID -> oACK high exactly 4 cycles after the strobe edge; iSTB held 10 cycles -> only one ACK. Drop iSTB in WAIT -> no ACK, no write.
4. iEVT[2] pulse, IRQ_EN=32'h4 -> STATUS=32'h4, oIRQ=1 next cycle. W1C 32'h4 on the same edge as a new iEVT[2] -> bit stays 1. Clear alone -> oIRQ=0.
5. Read 0x0200_0000 (outside window) -> no ACK within 20 cycles, oDAT=0. Read 0x0200_01F0 -> ACK, oDAT=0.
6. Force CYCLE to 32'hFFFF_FFFE, read twice 2 cycles apart -> wrap observed. Assert iRST mid-WAIT during a CTRL write -> CTRL stays CTRL_RST, oACK=0. Macro off: 0x0C reads 0.
